// File: rtl/traffic_light_controller_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : traffic_light_controller_pkg                               |
// | Description : Shared definitions for the traffic light controller:       |
// |               3-bit state encodings, Time_Sel codes, LED bit positions   |
// |               and the Moore light decode helpers.                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package traffic_light_controller_pkg;

    // Encoding 3'd7 is unused; the controller recovers from it to MAIN_GRN1.
    typedef enum logic [2:0] {
        ST_MAIN_GRN1 = 3'd0,
        ST_MAIN_GRN2 = 3'd1,
        ST_MAIN_YEL  = 3'd2,
        ST_WALK      = 3'd3,
        ST_SIDE_GRN  = 3'd4,
        ST_SIDE_EXT  = 3'd5,
        ST_SIDE_YEL  = 3'd6
    } tl_state_e;

    // Time_Sel codes
    localparam logic [1:0] TSEL_BASE = 2'b00;
    localparam logic [1:0] TSEL_EXT  = 2'b01;
    localparam logic [1:0] TSEL_YEL  = 2'b10;
    localparam logic [1:0] TSEL_NOP  = 2'b11;

    // Bit positions inside a {red,yellow,green} LED vector
    localparam int LED_RED = 2;
    localparam int LED_YEL = 1;
    localparam int LED_GRN = 0;

    function automatic logic [2:0] main_led_of(tl_state_e st);
        logic [2:0] led;
        led = 3'b000;
        case (st)
            ST_MAIN_GRN1, ST_MAIN_GRN2: led[LED_GRN] = 1'b1;
            ST_MAIN_YEL:                led[LED_YEL] = 1'b1;
            default:                    led[LED_RED] = 1'b1;
        endcase
        return led;
    endfunction

    function automatic logic [2:0] side_led_of(tl_state_e st);
        logic [2:0] led;
        led = 3'b000;
        case (st)
            ST_SIDE_GRN, ST_SIDE_EXT: led[LED_GRN] = 1'b1;
            ST_SIDE_YEL:              led[LED_YEL] = 1'b1;
            default:                  led[LED_RED] = 1'b1;
        endcase
        return led;
    endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_light_controller_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : traffic_interval_timer                                     |
// | Description : TW-bit down-counter holding the seconds remaining in the   |
// |               current light state. Loads on state entry, decrements on   |
// |               each tick, and flags expiry on the tick seen at zero.      |
// | Ports       : clk, Reset_n (async, active-low)                           |
// |               tick      - one-cycle 1 Hz enable                          |
// |               load      - load load_val this cycle (overrides tick)      |
// |               load_val  - duration-1 of the state being entered          |
// |               expired   - tick arrived while the count is zero           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module traffic_interval_timer #(
    parameter int            TW        = 4,
    parameter logic [TW-1:0] RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          Reset_n,
    input  logic          tick,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          expired
);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q <= RESET_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // With remaining = N-1 loaded on entry, the Nth tick lands on zero.
    assign expired = tick && (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/traffic_light_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : traffic_light_controller                                   |
// | Description : Sequences main/side street lights and the pedestrian walk  |
// |               lamp. Holds programmable base/extend/yellow intervals, the |
// |               side-sensor and walk-request flags, and the light FSM.     |
// | Ports       : clk, Reset_n (async, active-low), Tick_1Hz (1 Hz enable)  |
// |               Sensor_Sync, WR_Sync, Prog_Sync (synchronised inputs)      |
// |               Time_Sel[1:0], Time_Value[TW-1:0] (reprogram data)         |
// |               Main_LED[2:0], Side_LED[2:0] ({red,yellow,green})          |
// |               Walk_LED, State[2:0] (debug state encoding)                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module traffic_light_controller #(
    parameter int TW     = 4,
    parameter int T_BASE = 6,
    parameter int T_EXT  = 3,
    parameter int T_YEL  = 2
) (
    input  logic          clk,
    input  logic          Reset_n,
    input  logic          Tick_1Hz,
    input  logic          Sensor_Sync,
    input  logic          WR_Sync,
    input  logic          Prog_Sync,
    input  logic [1:0]    Time_Sel,
    input  logic [TW-1:0] Time_Value,
    output logic [2:0]    Main_LED,
    output logic [2:0]    Side_LED,
    output logic          Walk_LED,
    output logic [2:0]    State
);

    import traffic_light_controller_pkg::*;

    tl_state_e     state_q,     state_d;
    tl_state_e     expiry_next;
    logic [TW-1:0] base_q,      base_d;
    logic [TW-1:0] ext_q,       ext_d;
    logic [TW-1:0] yel_q,       yel_d;
    logic          sens_flag_q, sens_flag_d;
    logic          walk_pend_q, walk_pend_d;
    logic [2:0]    main_led_q,  main_led_d;
    logic [2:0]    side_led_q,  side_led_d;
    logic          walk_led_q,  walk_led_d;

    logic          state_legal;
    logic          timer_load;
    logic          timer_expired;
    logic [TW-1:0] entry_dur;
    logic [TW-1:0] timer_load_val;
    logic [TW-1:0] new_value;

    // A programmed interval of 0 would never expire sensibly; store it as 1.
    assign new_value = (Time_Value == '0) ? TW'(1) : Time_Value;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        ext_d       = ext_q;
        yel_d       = yel_q;
        sens_flag_d = sens_flag_q;
        walk_pend_d = walk_pend_q;
        timer_load  = 1'b0;
        state_legal = 1'b1;
        expiry_next = ST_MAIN_GRN1;

        case (state_q)
            ST_MAIN_GRN1: expiry_next = ST_MAIN_GRN2;
            ST_MAIN_GRN2: expiry_next = ST_MAIN_YEL;
            ST_MAIN_YEL:  expiry_next = walk_pend_q ? ST_WALK : ST_SIDE_GRN;
            ST_WALK:      expiry_next = ST_SIDE_GRN;
            ST_SIDE_GRN:  expiry_next = Sensor_Sync ? ST_SIDE_EXT : ST_SIDE_YEL;
            ST_SIDE_EXT:  expiry_next = ST_SIDE_YEL;
            ST_SIDE_YEL:  expiry_next = ST_MAIN_GRN1;
            default:      state_legal = 1'b0;
        endcase

        // Sensor seen on any MAIN_GRN1 cycle, including the expiry cycle,
        // so the MAIN_GRN2 duration below sees it through sens_flag_d.
        if ((state_q == ST_MAIN_GRN1) && Sensor_Sync) begin
            sens_flag_d = 1'b1;
        end
        if (WR_Sync) begin
            walk_pend_d = 1'b1;
        end

        if (Prog_Sync) begin
            case (Time_Sel)
                TSEL_BASE: base_d = new_value;
                TSEL_EXT:  ext_d  = new_value;
                TSEL_YEL:  yel_d  = new_value;
                TSEL_NOP:  ;
            endcase
            state_d     = ST_MAIN_GRN1;
            sens_flag_d = 1'b0;
            walk_pend_d = 1'b0;
            timer_load  = 1'b1;
        end else if (!state_legal) begin
            state_d    = ST_MAIN_GRN1;
            timer_load = 1'b1;
        end else if (timer_expired) begin
            state_d    = expiry_next;
            timer_load = 1'b1;
            if (state_q == ST_SIDE_YEL) begin
                sens_flag_d = 1'b0;
            end
            // Entering WALK serves the request; a same-cycle WR_Sync is absorbed.
            if (expiry_next == ST_WALK) begin
                walk_pend_d = 1'b0;
            end
        end

        // Duration of the state being entered, from the (possibly just
        // reprogrammed) interval values.
        case (state_d)
            ST_MAIN_GRN1, ST_SIDE_GRN: entry_dur = base_d;
            ST_MAIN_GRN2:              entry_dur = sens_flag_d ? ext_d : base_d;
            ST_MAIN_YEL,  ST_SIDE_YEL: entry_dur = yel_d;
            ST_WALK,      ST_SIDE_EXT: entry_dur = ext_d;
            default:                   entry_dur = base_d;
        endcase
        timer_load_val = entry_dur - 1'b1;

        // Lights are decoded from the next state and registered alongside it
        // so they change on the same edge as State.
        main_led_d = main_led_of(state_d);
        side_led_d = side_led_of(state_d);
        walk_led_d = (state_d == ST_WALK);
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_MAIN_GRN1;
            base_q      <= TW'(T_BASE);
            ext_q       <= TW'(T_EXT);
            yel_q       <= TW'(T_YEL);
            sens_flag_q <= 1'b0;
            walk_pend_q <= 1'b0;
            main_led_q  <= 3'b001;
            side_led_q  <= 3'b100;
            walk_led_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            ext_q       <= ext_d;
            yel_q       <= yel_d;
            sens_flag_q <= sens_flag_d;
            walk_pend_q <= walk_pend_d;
            main_led_q  <= main_led_d;
            side_led_q  <= side_led_d;
            walk_led_q  <= walk_led_d;
        end
    end

    traffic_interval_timer #(
        .TW        (TW),
        .RESET_VAL (TW'(T_BASE - 1))
    ) u_timer (
        .clk      (clk),
        .Reset_n  (Reset_n),
        .tick     (Tick_1Hz),
        .load     (timer_load),
        .load_val (timer_load_val),
        .expired  (timer_expired)
    );

    assign Main_LED = main_led_q;
    assign Side_LED = side_led_q;
    assign Walk_LED = walk_led_q;
    assign State    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_traffic_light_controller                                |
// | Description : Self-checking bench for traffic_light_controller. Directed |
// |               scenario tasks measure state lengths in ticks; a random    |
// |               phase compares every cycle against a tick-counting model.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_traffic_light_controller;
    import traffic_light_controller_pkg::*;

    localparam int TW = 4;

    logic          clk;
    logic          Reset_n;
    logic          Tick_1Hz;
    logic          Sensor_Sync;
    logic          WR_Sync;
    logic          Prog_Sync;
    logic [1:0]    Time_Sel;
    logic [TW-1:0] Time_Value;
    logic [2:0]    Main_LED;
    logic [2:0]    Side_LED;
    logic          Walk_LED;
    logic [2:0]    State;

    int checks = 0;
    int errors = 0;
    int ticks_seen = 0;
    int tick_div = 0;

    traffic_light_controller #(.TW(TW), .T_BASE(6), .T_EXT(3), .T_YEL(2)) dut (
        .clk         (clk),
        .Reset_n     (Reset_n),
        .Tick_1Hz    (Tick_1Hz),
        .Sensor_Sync (Sensor_Sync),
        .WR_Sync     (WR_Sync),
        .Prog_Sync   (Prog_Sync),
        .Time_Sel    (Time_Sel),
        .Time_Value  (Time_Value),
        .Main_LED    (Main_LED),
        .Side_LED    (Side_LED),
        .Walk_LED    (Walk_LED),
        .State       (State)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tick_1Hz: one cycle in every four
    initial begin
        Tick_1Hz = 1'b0;
        forever begin
            @(negedge clk);
            tick_div++;
            Tick_1Hz = ((tick_div % 4) == 0);
        end
    end

    always @(posedge clk) if (Tick_1Hz) ticks_seen++;

    // ---------------- expected lights from the light rules ----------------
    function automatic logic [2:0] exp_main(logic [2:0] s);
        if (s == ST_MAIN_GRN1 || s == ST_MAIN_GRN2) return 3'b001;
        if (s == ST_MAIN_YEL) return 3'b010;
        return 3'b100;
    endfunction
    function automatic logic [2:0] exp_side(logic [2:0] s);
        if (s == ST_SIDE_GRN || s == ST_SIDE_EXT) return 3'b001;
        if (s == ST_SIDE_YEL) return 3'b010;
        return 3'b100;
    endfunction
    function automatic logic exp_walk(logic [2:0] s);
        return (s == ST_WALK);
    endfunction

    // ---------------- reference model: ticks elapsed per state ------------
    logic [2:0] m_state;
    int         m_elapsed, m_dur, m_base, m_ext, m_yel, m_val;
    bit         m_sens, m_walk, m_sens_n, m_walk_n;
    logic [2:0] m_nxt;

    function automatic int m_len(logic [2:0] s, bit sens, int b, int e, int y);
        if (s == ST_MAIN_GRN1 || s == ST_SIDE_GRN) return b;
        if (s == ST_MAIN_GRN2) return sens ? e : b;
        if (s == ST_MAIN_YEL || s == ST_SIDE_YEL) return y;
        return e;
    endfunction

    always @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_state = ST_MAIN_GRN1; m_elapsed = 0; m_dur = 6;
            m_base = 6; m_ext = 3; m_yel = 2; m_sens = 0; m_walk = 0;
        end else begin
            m_sens_n = m_sens || (m_state == ST_MAIN_GRN1 && Sensor_Sync);
            m_walk_n = m_walk || WR_Sync;
            if (Prog_Sync) begin
                m_val = (Time_Value == 0) ? 1 : int'(Time_Value);
                if (Time_Sel == 2'd0) m_base = m_val;
                else if (Time_Sel == 2'd1) m_ext = m_val;
                else if (Time_Sel == 2'd2) m_yel = m_val;
                m_sens_n = 0; m_walk_n = 0;
                m_state = ST_MAIN_GRN1; m_elapsed = 0;
                m_dur = m_base;
            end else if (Tick_1Hz) begin
                m_elapsed++;
                if (m_elapsed == m_dur) begin
                    case (m_state)
                        ST_MAIN_GRN1: m_nxt = ST_MAIN_GRN2;
                        ST_MAIN_GRN2: m_nxt = ST_MAIN_YEL;
                        ST_MAIN_YEL:  m_nxt = m_walk ? ST_WALK : ST_SIDE_GRN;
                        ST_WALK:      m_nxt = ST_SIDE_GRN;
                        ST_SIDE_GRN:  m_nxt = Sensor_Sync ? ST_SIDE_EXT : ST_SIDE_YEL;
                        ST_SIDE_EXT:  m_nxt = ST_SIDE_YEL;
                        default:      m_nxt = ST_MAIN_GRN1;
                    endcase
                    if (m_state == ST_SIDE_YEL) m_sens_n = 0;
                    if (m_nxt == ST_WALK) m_walk_n = 0;
                    m_state = m_nxt; m_elapsed = 0;
                    m_dur = m_len(m_nxt, m_sens_n, m_base, m_ext, m_yel);
                end
            end
            m_sens = m_sens_n; m_walk = m_walk_n;
        end
    end

    // ---------------- measurement: call on the entry negedge of st --------
    task automatic measure_state(input logic [2:0] st, input bit pulse_wr,
                                 output bit entered, output int ticks, output bit timed_out,
                                 output logic [2:0] main_e, output logic [2:0] side_e,
                                 output logic walk_e, output bit walk_seen);
        int t0;
        entered = (State === st);
        main_e = Main_LED; side_e = Side_LED; walk_e = Walk_LED;
        walk_seen = (Walk_LED === 1'b1);
        t0 = ticks_seen;
        timed_out = 1'b1;
        if (pulse_wr) WR_Sync = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (pulse_wr) WR_Sync = 1'b0;
            if (State !== st) begin
                timed_out = 1'b0;
                break;
            end
            if (Walk_LED === 1'b1) walk_seen = 1'b1;
        end
        ticks = ticks_seen - t0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        Reset_n = 1'b0; Sensor_Sync = 0; WR_Sync = 0; Prog_Sync = 0;
        Time_Sel = 2'b11; Time_Value = '0;
        repeat (3) @(negedge clk);
        checks++; if (State !== ST_MAIN_GRN1) begin errors++; $display("FAIL reset_state: got %0d want %0d", State, ST_MAIN_GRN1); end
        checks++; if (Main_LED !== 3'b001) begin errors++; $display("FAIL reset_main: got %b want 001", Main_LED); end
        checks++; if (Side_LED !== 3'b100) begin errors++; $display("FAIL reset_side: got %b want 100", Side_LED); end
        checks++; if (Walk_LED !== 1'b0) begin errors++; $display("FAIL reset_walk: got %b want 0", Walk_LED); end
        Reset_n = 1'b1;
    endtask

    task automatic test_default_cycle();
        logic [2:0] sts [5];
        int tk [5];
        bit ok, to, ws, any_walk; int n; logic [2:0] me, se; logic we;
        sts = '{ST_MAIN_GRN1, ST_MAIN_GRN2, ST_MAIN_YEL, ST_SIDE_GRN, ST_SIDE_YEL};
        tk  = '{6, 6, 2, 6, 2};
        any_walk = 0;
        for (int i = 0; i < 5; i++) begin
            measure_state(sts[i], 1'b0, ok, n, to, me, se, we, ws);
            if (ws) any_walk = 1;
            checks++; if (!ok || to) begin errors++; $display("FAIL default_state[%0d]: entered=%0b timed_out=%0b want state %0d", i, ok, to, sts[i]); end
            checks++; if (n != tk[i]) begin errors++; $display("FAIL default_ticks[%0d]: got %0d want %0d", i, n, tk[i]); end
            checks++; if ({me, se, we} !== {exp_main(sts[i]), exp_side(sts[i]), exp_walk(sts[i])})
                begin errors++; $display("FAIL default_leds[%0d]: got %b/%b/%b want %b/%b/%b", i, me, se, we, exp_main(sts[i]), exp_side(sts[i]), exp_walk(sts[i])); end
        end
        checks++; if (any_walk) begin errors++; $display("FAIL default_walk_lamp: got 1 want 0"); end
        checks++; if (State !== ST_MAIN_GRN1) begin errors++; $display("FAIL default_wrap: got %0d want %0d", State, ST_MAIN_GRN1); end
    endtask

    task automatic test_sensor();
        logic [2:0] sts [6];
        int tk [6];
        bit ok, to, ws; int n; logic [2:0] me, se; logic we;
        sts = '{ST_MAIN_GRN1, ST_MAIN_GRN2, ST_MAIN_YEL, ST_SIDE_GRN, ST_SIDE_EXT, ST_SIDE_YEL};
        tk  = '{6, 3, 2, 6, 3, 2};
        Sensor_Sync = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) Sensor_Sync = 1'b0;
            measure_state(sts[i], 1'b0, ok, n, to, me, se, we, ws);
            checks++; if (!ok || to) begin errors++; $display("FAIL sensor_state[%0d]: entered=%0b timed_out=%0b want state %0d", i, ok, to, sts[i]); end
            checks++; if (n != tk[i]) begin errors++; $display("FAIL sensor_ticks[%0d]: got %0d want %0d", i, n, tk[i]); end
            checks++; if ({me, se, we} !== {exp_main(sts[i]), exp_side(sts[i]), exp_walk(sts[i])})
                begin errors++; $display("FAIL sensor_leds[%0d]: got %b/%b/%b want %b/%b/%b", i, me, se, we, exp_main(sts[i]), exp_side(sts[i]), exp_walk(sts[i])); end
        end
    endtask

    task automatic test_walk();
        logic [2:0] sts [6];
        int tk [6];
        bit ok, to, ws; int n; logic [2:0] me, se; logic we;
        sts = '{ST_MAIN_GRN1, ST_MAIN_GRN2, ST_MAIN_YEL, ST_WALK, ST_SIDE_GRN, ST_SIDE_YEL};
        tk  = '{6, 6, 2, 3, 6, 2};
        for (int i = 0; i < 6; i++) begin
            measure_state(sts[i], (i == 1), ok, n, to, me, se, we, ws);
            checks++; if (!ok || to) begin errors++; $display("FAIL walk_state[%0d]: entered=%0b timed_out=%0b want state %0d", i, ok, to, sts[i]); end
            checks++; if (n != tk[i]) begin errors++; $display("FAIL walk_ticks[%0d]: got %0d want %0d", i, n, tk[i]); end
            checks++; if ({me, se, we} !== {exp_main(sts[i]), exp_side(sts[i]), exp_walk(sts[i])})
                begin errors++; $display("FAIL walk_leds[%0d]: got %b/%b/%b want %b/%b/%b", i, me, se, we, exp_main(sts[i]), exp_side(sts[i]), exp_walk(sts[i])); end
        end
    endtask

    task automatic test_reprogram_yellow();
        logic [2:0] pre [4];
        int pre_tk [4];
        logic [2:0] sts [5];
        int tk [5];
        bit ok, to, ws; int n; logic [2:0] me, se; logic we;
        pre = '{ST_MAIN_GRN1, ST_MAIN_GRN2, ST_MAIN_YEL, ST_SIDE_GRN};
        pre_tk = '{6, 3, 2, 6};
        sts = '{ST_MAIN_GRN1, ST_MAIN_GRN2, ST_MAIN_YEL, ST_SIDE_GRN, ST_SIDE_YEL};
        tk  = '{6, 6, 5, 6, 5};
        Sensor_Sync = 1'b1;
        for (int i = 0; i < 4; i++) begin
            measure_state(pre[i], 1'b0, ok, n, to, me, se, we, ws);
            checks++; if (!ok || to || n != pre_tk[i]) begin errors++; $display("FAIL prog_pre[%0d]: entered=%0b timed_out=%0b ticks %0d want %0d", i, ok, to, n, pre_tk[i]); end
        end
        checks++; if (State !== ST_SIDE_EXT) begin errors++; $display("FAIL prog_in_side_ext: got %0d want %0d", State, ST_SIDE_EXT); end
        Sensor_Sync = 1'b0; Prog_Sync = 1'b1; Time_Sel = 2'b10; Time_Value = 4'd5;
        @(negedge clk);
        Prog_Sync = 1'b0; Time_Sel = 2'b11; Time_Value = '0;
        checks++; if (State !== ST_MAIN_GRN1 || Main_LED !== 3'b001 || Side_LED !== 3'b100)
            begin errors++; $display("FAIL prog_restart: got state %0d main %b side %b want %0d 001 100", State, Main_LED, Side_LED, ST_MAIN_GRN1); end
        for (int i = 0; i < 5; i++) begin
            measure_state(sts[i], 1'b0, ok, n, to, me, se, we, ws);
            checks++; if (!ok || to) begin errors++; $display("FAIL prog_state[%0d]: entered=%0b timed_out=%0b want state %0d", i, ok, to, sts[i]); end
            checks++; if (n != tk[i]) begin errors++; $display("FAIL prog_ticks[%0d]: got %0d want %0d", i, n, tk[i]); end
        end
    endtask

    task automatic test_prog_zero_and_noop();
        logic [2:0] sts [5];
        int tk [5];
        bit ok, to, ws; int n, off; logic [2:0] me, se; logic we;
        sts = '{ST_MAIN_GRN1, ST_MAIN_GRN2, ST_MAIN_YEL, ST_SIDE_GRN, ST_SIDE_YEL};
        tk  = '{1, 1, 5, 1, 5};
        Prog_Sync = 1'b1; Time_Sel = 2'b00; Time_Value = 4'd0;
        @(negedge clk);
        Prog_Sync = 1'b0;
        for (int i = 0; i < 5; i++) begin
            measure_state(sts[i], 1'b0, ok, n, to, me, se, we, ws);
            checks++; if (!ok || to || n != tk[i]) begin errors++; $display("FAIL zero_base[%0d]: entered=%0b timed_out=%0b ticks %0d want %0d", i, ok, to, n, tk[i]); end
        end
        // Time_Sel=11 must leave all intervals alone but still restart the FSM
        @(negedge clk);
        Prog_Sync = 1'b1; Time_Sel = 2'b11; Time_Value = 4'd9;
        @(negedge clk);
        Prog_Sync = 1'b0;
        for (int i = 0; i < 3; i++) begin
            measure_state(sts[i], 1'b0, ok, n, to, me, se, we, ws);
            checks++; if (!ok || to || n != tk[i]) begin errors++; $display("FAIL noop_sel[%0d]: entered=%0b timed_out=%0b ticks %0d want %0d", i, ok, to, n, tk[i]); end
        end
        // Prog_Sync held high parks the FSM in MAIN_GRN1 across several ticks
        Prog_Sync = 1'b1;
        off = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (State !== ST_MAIN_GRN1) off++;
        end
        Prog_Sync = 1'b0; Time_Sel = 2'b11; Time_Value = '0;
        checks++; if (off != 0) begin errors++; $display("FAIL prog_park: left MAIN_GRN1 on %0d cycles want 0", off); end
    endtask

    task automatic test_async_reset();
        logic [2:0] sts [3];
        int tk [3];
        bit ok, to, ws, found; int n; logic [2:0] me, se; logic we;
        sts = '{ST_MAIN_GRN1, ST_MAIN_GRN2, ST_MAIN_YEL};
        tk  = '{6, 6, 2};
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (State === ST_SIDE_GRN) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL async_reach_side_grn: timed out want state %0d", ST_SIDE_GRN); end
        repeat (2) @(negedge clk);
        #2 Reset_n = 1'b0;
        #1;
        checks++; if (State !== ST_MAIN_GRN1) begin errors++; $display("FAIL async_state: got %0d want %0d", State, ST_MAIN_GRN1); end
        checks++; if (Main_LED !== 3'b001 || Side_LED !== 3'b100 || Walk_LED !== 1'b0)
            begin errors++; $display("FAIL async_leds: got %b/%b/%b want 001/100/0", Main_LED, Side_LED, Walk_LED); end
        @(negedge clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            measure_state(sts[i], 1'b0, ok, n, to, me, se, we, ws);
            checks++; if (!ok || to || n != tk[i]) begin errors++; $display("FAIL async_defaults[%0d]: entered=%0b timed_out=%0b ticks %0d want %0d", i, ok, to, n, tk[i]); end
        end
    endtask

    task automatic test_random();
        @(negedge clk);
        Reset_n = 1'b0; Sensor_Sync = 0; WR_Sync = 0; Prog_Sync = 0;
        @(negedge clk);
        Reset_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            checks++;
            if ({State, Main_LED, Side_LED, Walk_LED} !==
                {m_state, exp_main(m_state), exp_side(m_state), exp_walk(m_state)}) begin
                errors++;
                $display("FAIL random_cycle %0d: got state %0d %b/%b/%b want state %0d %b/%b/%b", c,
                         State, Main_LED, Side_LED, Walk_LED,
                         m_state, exp_main(m_state), exp_side(m_state), exp_walk(m_state));
            end
            if ($urandom_range(0, 15) == 0) Sensor_Sync = ~Sensor_Sync;
            WR_Sync    = ($urandom_range(0, 39) == 0);
            Prog_Sync  = ($urandom_range(0, 149) == 0);
            Time_Sel   = 2'($urandom_range(0, 3));
            Time_Value = TW'($urandom_range(0, 7));
        end
        Sensor_Sync = 0; WR_Sync = 0; Prog_Sync = 0;
    endtask

    initial begin
        test_reset();
        test_default_cycle();
        test_sensor();
        test_walk();
        test_reprogram_yellow();
        test_prog_zero_and_noop();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
